// File: rtl/sys_bridge_n_if.sv
// CPU-to-peripheral bus bundle for sys_bridge_n: CPU request/response side plus the
// flattened per-slave channel. The bridge uses the slave view; the environment uses master.
interface sys_bridge_n_if #(
  parameter int N_SLV = 4
);
  logic                   pr_req;
  logic [31:0]            pr_addr;
  logic [31:0]            pr_wdata;
  logic [3:0]             pr_byteen;
  logic [31:0]            pr_rdata;
  logic                   pr_done;
  logic                   pr_err;
  logic                   pr_busy;
  logic [31:0]            err_addr;
  logic [N_SLV-1:0]       s_sel;
  logic [31:0]            s_addr;
  logic [31:0]            s_wdata;
  logic [3:0]             s_byteen;
  logic [32*N_SLV-1:0]    s_rdata;
  logic [N_SLV-1:0]       s_ready;

  modport slave (
    input  pr_req, pr_addr, pr_wdata, pr_byteen, s_rdata, s_ready,
    output pr_rdata, pr_done, pr_err, pr_busy, err_addr,
           s_sel, s_addr, s_wdata, s_byteen
  );

  modport master (
    output pr_req, pr_addr, pr_wdata, pr_byteen, s_rdata, s_ready,
    input  pr_rdata, pr_done, pr_err, pr_busy, err_addr,
           s_sel, s_addr, s_wdata, s_byteen
  );
endinterface

// File: rtl/sys_bridge_n.sv
// Registered bridge from the CPU M-stage port to N_SLV base/mask-decoded slaves,
// with a bounded ready wait and a latched faulting address on bus errors.
//   state  | meaning
//   IDLE   | waiting for pr_req; decode and launch or flag a miss
//   ACCESS | slave selected, waiting for its ready or the timeout
//   RESP   | one-cycle pr_done/pr_err pulse back to the CPU
module sys_bridge_n #(
  parameter int                   N_SLV    = 4,
  parameter logic [32*N_SLV-1:0]  BASE_VEC = {32'h7f20, 32'h7f10, 32'h7f00, 32'h0000},
  parameter logic [32*N_SLV-1:0]  MASK_VEC = {32'hfffffff0, 32'hfffffff0, 32'hfffffff0, 32'hffffc000},
  parameter int                   TIMEOUT  = 15
) (
  input  logic           clk,
  input  logic           reset,
  sys_bridge_n_if.slave  bus
);

  localparam int          IDXW     = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [N_SLV-1:0]  sel_q, sel_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       err_addr_q, err_addr_d;
  logic              err_q, err_d;

  logic              hit;
  logic [IDXW-1:0]   hit_idx;
  logic              ready_sel;
  logic [31:0]       rdata_sel;

  // Scan from the top index down so the lowest matching window wins on overlap.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((bus.pr_addr & MASK_VEC[32*i +: 32]) == (BASE_VEC[32*i +: 32] & MASK_VEC[32*i +: 32])) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
  end

  assign ready_sel = bus.s_ready[idx_q];
  assign rdata_sel = bus.s_rdata[32*idx_q +: 32];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (bus.pr_req) begin
          if (hit) begin
            addr_d  = bus.pr_addr;
            wdata_d = bus.pr_wdata;
            be_d    = bus.pr_byteen;
            idx_d   = hit_idx;
            sel_d   = N_SLV'(1) << hit_idx;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = ACCESS;
          end else begin
            err_d      = 1'b1;
            err_addr_d = bus.pr_addr;
            rdata_d    = '0;
            state_d    = RESP;
          end
        end
      end
      ACCESS: begin
        // Ready is checked first so a ready on the last allowed cycle still succeeds.
        if (ready_sel) begin
          rdata_d = (be_q == 4'h0) ? rdata_sel : 32'h0;
          sel_d   = '0;
          be_d    = '0;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          sel_d      = '0;
          be_d       = '0;
          err_d      = 1'b1;
          err_addr_d = addr_q;
          rdata_d    = '0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        be_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rdata_q    <= rdata_d;
      err_addr_q <= err_addr_d;
      err_q      <= err_d;
    end
  end

  assign bus.pr_done  = (state_q == RESP);
  assign bus.pr_err   = (state_q == RESP) && err_q;
  assign bus.pr_busy  = (state_q != IDLE);
  assign bus.pr_rdata = rdata_q;
  assign bus.err_addr = err_addr_q;
  assign bus.s_sel    = sel_q;
  assign bus.s_addr   = addr_q;
  assign bus.s_wdata  = wdata_q;
  assign bus.s_byteen = be_q;

endmodule

// File: tb/tb_sys_bridge_n.sv
// Randomized self-checking bench for sys_bridge_n against a transaction-level model:
// window decode, wait/timeout outcome, latency, read data and latched error address.
module tb_sys_bridge_n;

  localparam int N  = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sys_bridge_n_if #(.N_SLV(N)) bus ();
  sys_bridge_n dut (.clk(clk), .reset(reset), .bus(bus));

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic [31:0] base_a [N] = '{32'h0000_0000, 32'h0000_7f00, 32'h0000_7f10, 32'h0000_7f20};
  logic [31:0] mask_a [N] = '{32'hffff_c000, 32'hffff_fff0, 32'hffff_fff0, 32'hffff_fff0};
  logic [31:0] rd_a   [N];
  logic [31:0] m_err_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & mask_a[i]) == (base_a[i] & mask_a[i])) return i;
    return -1;
  endfunction

  // Called at a negedge. lead=1 when issued while the previous pr_done is showing.
  // w = number of wait cycles before the selected slave raises ready.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input int w, input bit toggle, input int lead);
    int          idx;
    int          exp_lat;
    bit          exp_err;
    logic [31:0] exp_rd;
    logic [N-1:0] noise;
    bit          done;
    int          k;

    idx     = ref_decode(a);
    exp_rd  = 32'h0;
    if (idx < 0) begin
      exp_lat = 1;
      exp_err = 1'b1;
    end else if (w <= TO - 1) begin
      exp_lat = w + 2;
      exp_err = 1'b0;
      exp_rd  = (be == 4'h0) ? rd_a[idx] : 32'h0;
    end else begin
      exp_lat = TO + 1;
      exp_err = 1'b1;
    end
    if (exp_err) m_err_addr = a;

    for (int i = 0; i < N; i++) bus.s_rdata[32*i +: 32] = rd_a[i];
    noise = N'($urandom);
    if (idx >= 0) noise[idx] = 1'b0;
    bus.s_ready   = noise;
    bus.pr_req    = 1'b1;
    bus.pr_addr   = a;
    bus.pr_wdata  = wd;
    bus.pr_byteen = be;

    done = 1'b0;
    for (int cyc = 1; cyc <= TO + 4 + lead; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc <= lead) begin
        chk("b2b_idle_gap", {30'h0, bus.pr_busy, bus.pr_done}, 32'h0);
        continue;
      end
      k = cyc - lead;
      if (bus.pr_done) begin
        chk("latency", k, exp_lat);
        chk("pr_err", bus.pr_err, exp_err);
        if (idx >= 0) chk("pr_rdata", bus.pr_rdata, exp_rd);
        chk("err_addr", bus.err_addr, m_err_addr);
        chk("sel_at_done", bus.s_sel, 0);
        chk("busy_at_done", bus.pr_busy, 1);
        done = 1'b1;
        break;
      end
      chk("busy", bus.pr_busy, 1);
      if (idx >= 0) begin
        chk("s_sel", bus.s_sel, 32'(1) << idx);
        chk("s_addr", bus.s_addr, a);
        chk("s_wdata", bus.s_wdata, wd);
        chk("s_byteen", bus.s_byteen, be);
      end
      noise = N'($urandom);
      if (idx >= 0) noise[idx] = ((k - 1) == w);
      bus.s_ready = noise;
      if (toggle) begin
        bus.pr_req    = 1'($urandom);
        bus.pr_addr   = $urandom;
        bus.pr_wdata  = $urandom;
        bus.pr_byteen = 4'($urandom);
      end
    end
    chk("done_seen", done, 1);
    bus.pr_req  = 1'b0;
    bus.s_ready = '0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int          lead;

    reset         = 1'b1;
    bus.pr_req    = 1'b0;
    bus.pr_addr   = '0;
    bus.pr_wdata  = '0;
    bus.pr_byteen = '0;
    bus.s_rdata   = '0;
    bus.s_ready   = '0;
    m_err_addr    = '0;
    for (int i = 0; i < N; i++) rd_a[i] = $urandom;

    repeat (2) @(negedge clk);
    chk("rst_done",     bus.pr_done,  0);
    chk("rst_err",      bus.pr_err,   0);
    chk("rst_busy",     bus.pr_busy,  0);
    chk("rst_err_addr", bus.err_addr, 0);
    chk("rst_sel",      bus.s_sel,    0);
    chk("rst_s_addr",   bus.s_addr,   0);
    chk("rst_s_wdata",  bus.s_wdata,  0);
    chk("rst_byteen",   bus.s_byteen, 0);
    chk("rst_rdata",    bus.pr_rdata, 0);
    reset = 1'b0;
    idle_cycle();

    rd_a[0] = 32'hDEAD_BEEF;
    run_txn(32'h0000_1004, 32'h0, 4'h0, 0, 1'b0, 0);
    idle_cycle();
    run_txn(32'h0000_7f14, 32'h1234_5678, 4'hF, 3, 1'b0, 0);
    idle_cycle();
    run_txn(32'h0000_8000, 32'h0, 4'h0, 0, 1'b0, 0);
    idle_cycle();
    run_txn(32'h0000_7f04, 32'h0, 4'h0, 1000, 1'b0, 0);
    idle_cycle();
    rd_a[3] = $urandom;
    run_txn(32'h0000_7f28, 32'h0, 4'h0, TO - 1, 1'b0, 0);
    run_txn(32'h0000_0010, 32'hCAFE_0001, 4'h3, 1, 1'b0, 1);
    idle_cycle();
    run_txn(32'h0000_7f1c, 32'h5555_AAAA, 4'h0, 5, 1'b1, 0);
    idle_cycle();
    run_txn(32'h0001_0000, 32'h0, 4'h1, 0, 1'b0, 0);

    idle_cycle();
    bus.pr_req   = 1'b1;
    bus.pr_addr  = 32'h0000_7f08;
    bus.pr_byteen = 4'h0;
    bus.s_ready  = '0;
    repeat (2) idle_cycle();
    chk("pre_rst_sel", bus.s_sel, 32'h2);
    reset = 1'b1;
    #1;
    m_err_addr = '0;
    chk("midrst_sel",      bus.s_sel,    0);
    chk("midrst_busy",     bus.pr_busy,  0);
    chk("midrst_err_addr", bus.err_addr, 0);
    chk("midrst_done",     bus.pr_done,  0);
    bus.pr_req = 1'b0;
    repeat (2) begin
      idle_cycle();
      chk("rst_hold_done", bus.pr_done, 0);
    end
    reset = 1'b0;
    idle_cycle();
    rd_a[1] = $urandom;
    run_txn(32'h0000_7f08, 32'h0, 4'h0, 2, 1'b0, 0);

    for (int t = 0; t < 150; t++) begin
      case ($urandom % 5)
        0: a = $urandom & 32'h0000_3fff;
        1: a = 32'h0000_7f00 | ($urandom & 32'hf);
        2: a = 32'h0000_7f10 | ($urandom & 32'hf);
        3: a = 32'h0000_7f20 | ($urandom & 32'hf);
        default: a = $urandom;
      endcase
      for (int i = 0; i < N; i++) rd_a[i] = $urandom;
      lead = int'($urandom % 2);
      if (lead == 0) idle_cycle();
      run_txn(a, $urandom, ($urandom % 2) ? 4'h0 : 4'($urandom_range(1, 15)),
              int'($urandom_range(0, TO + 2)), 1'($urandom), lead);
    end

    idle_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
